vnp4_egress_router: RTL

- Egress-side counterpart of the shell's ingress merger. Takes the single packet stream leaving the Vitis Net P4 core, plus its per-packet user metadata, and steers each packet to exactly one destination lane: a QDMA C2H PF or a CMAC TX adapter.
- Decodes routing fields on the packet head, then forwards or drops the whole packet atomically.
- Sits in the 250 MHz user plugin between the VNP4 core output and the C2H/TX 250 MHz stream ports.

---
 rtl/vnp4_egress_router.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/vnp4_egress_router.sv
// -----------------------------------------------------------------------------
// vnp4_egress_router
//
// Steers each packet leaving the Vitis Net P4 core to exactly one destination
// lane: a QDMA C2H physical function (lanes 0..NUM_PHYS_FUNC-1) or a CMAC TX
// adapter (lanes NUM_PHYS_FUNC..NUM_LANE-1). Routing fields are decoded on the
// packet head; the whole packet is then either forwarded to the selected lane
// or dropped.
//
// Optional build macro: VNP4_EGRESS_DROP_STATS_EN
//   When defined, adds a saturating 32-bit drop counter (drop_cnt) with a
//   synchronous clear (drop_cnt_clr, clear wins over a coincident increment).
//
// Ports:
//   aclk, areset            stream clock, synchronous active-high reset
//   s_axis_*                packet stream from VNP4 (512-bit data, 64-bit keep)
//   s_user_*                per-packet metadata, valid only on the head beat
//   m_axis_tdata/tkeep/tlast shared data to all lanes
//   m_axis_tuser_size/src   metadata latched at head, held for whole packet
//   m_axis_tvalid           per-lane valid (one-hot or zero)
//   m_axis_tready           per-lane ready
//   drop_cnt, drop_cnt_clr  (optional) dropped-packet counter and clear
// -----------------------------------------------------------------------------
module vnp4_egress_router #(
  parameter int NUM_PHYS_FUNC = 1,
  parameter int NUM_CMAC_PORT = 1
) (
  input  logic                                   aclk,
  input  logic                                   areset,
  input  logic [511:0]                           s_axis_tdata,
  input  logic [63:0]                            s_axis_tkeep,
  input  logic                                   s_axis_tlast,
  input  logic                                   s_axis_tvalid,
  output logic                                   s_axis_tready,
  input  logic                                   s_user_valid,
  input  logic [15:0]                            s_user_size,
  input  logic [15:0]                            s_user_src_pf,
  input  logic [15:0]                            s_user_src_cmac,
  input  logic [15:0]                            s_user_dst_pf,
  input  logic [15:0]                            s_user_dst_cmac,
  input  logic                                   s_user_to_direction,
  output logic [511:0]                           m_axis_tdata,
  output logic [63:0]                            m_axis_tkeep,
  output logic                                   m_axis_tlast,
  output logic [15:0]                            m_axis_tuser_size,
  output logic [15:0]                            m_axis_tuser_src,
  output logic [NUM_PHYS_FUNC+NUM_CMAC_PORT-1:0] m_axis_tvalid,
  input  logic [NUM_PHYS_FUNC+NUM_CMAC_PORT-1:0] m_axis_tready
`ifdef VNP4_EGRESS_DROP_STATS_EN
  ,
  output logic [31:0]                            drop_cnt,
  input  logic                                   drop_cnt_clr
`endif
);

  localparam int DATA_W   = 512;
  localparam int KEEP_W   = 64;
  localparam int NUM_LANE = NUM_PHYS_FUNC + NUM_CMAC_PORT;
  localparam int SEL_W    = (NUM_LANE > 1) ? $clog2(NUM_LANE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_t;

  function automatic logic [NUM_LANE-1:0] lane_onehot(input logic [SEL_W-1:0] s);
    lane_onehot    = '0;
    lane_onehot[s] = 1'b1;
  endfunction

  state_t              state;
  logic [SEL_W-1:0]    sel;
  logic [NUM_LANE-1:0] vld_p0;
  logic [DATA_W-1:0]   tdata_p0;
  logic [KEEP_W-1:0]   tkeep_p0;
  logic                tlast_p0;
  logic [15:0]         size_p0;
  logic [15:0]         src_p0;

  logic                head_legal;
  logic [SEL_W-1:0]    head_sel;
  logic                out_full;
  logic                out_drain;
  logic                accept;

  // Destination compare is done at full 16-bit width so large indices such as
  // 16'hFFFF can never alias onto a real lane. An orphan beat (no metadata)
  // decodes as illegal and the remainder of that packet is discarded.
  always_comb begin
    head_legal = 1'b0;
    head_sel   = '0;
    if (s_user_valid) begin
      if (!s_user_to_direction) begin
        head_legal = {16'd0, s_user_dst_pf} < 32'(NUM_PHYS_FUNC);
        head_sel   = SEL_W'(s_user_dst_pf);
      end else begin
        head_legal = {16'd0, s_user_dst_cmac} < 32'(NUM_CMAC_PORT);
        head_sel   = SEL_W'(32'(NUM_PHYS_FUNC) + {16'd0, s_user_dst_cmac});
      end
    end
  end

  assign out_full  = |vld_p0;
  assign out_drain = |(vld_p0 & m_axis_tready);

  // Dropped beats never touch the output register, so DROP accepts freely even
  // while a previous packet's tail is still waiting downstream.
  assign s_axis_tready = !areset &&
                         ((state == DROP) || !out_full || m_axis_tready[sel]);
  assign accept        = s_axis_tvalid && s_axis_tready;

  // ---- stage p0: routing FSM and output register ----
  always_ff @(posedge aclk) begin
    if (areset) begin
      state    <= IDLE;
      sel      <= '0;
      vld_p0   <= '0;
      tdata_p0 <= '0;
      tkeep_p0 <= '0;
      tlast_p0 <= 1'b0;
      size_p0  <= '0;
      src_p0   <= '0;
    end else begin
      if (out_drain) vld_p0 <= '0;
      if (accept) begin
        case (state)
          IDLE: begin
            if (head_legal) begin
              tdata_p0 <= s_axis_tdata;
              tkeep_p0 <= s_axis_tkeep;
              tlast_p0 <= s_axis_tlast;
              vld_p0   <= lane_onehot(head_sel);
              sel      <= head_sel;
              size_p0  <= s_user_size;
              src_p0   <= s_user_to_direction ? s_user_src_pf : s_user_src_cmac;
              state    <= s_axis_tlast ? IDLE : FWD;
            end else begin
              state    <= s_axis_tlast ? IDLE : DROP;
            end
          end
          FWD: begin
            tdata_p0 <= s_axis_tdata;
            tkeep_p0 <= s_axis_tkeep;
            tlast_p0 <= s_axis_tlast;
            vld_p0   <= lane_onehot(sel);
            if (s_axis_tlast) state <= IDLE;
          end
          DROP: begin
            if (s_axis_tlast) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign m_axis_tdata      = tdata_p0;
  assign m_axis_tkeep      = tkeep_p0;
  assign m_axis_tlast      = tlast_p0;
  assign m_axis_tuser_size = size_p0;
  assign m_axis_tuser_src  = src_p0;
  assign m_axis_tvalid     = vld_p0;

`ifdef VNP4_EGRESS_DROP_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    sat_inc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic        drop_event;
  logic [31:0] drop_cnt_p0;

  // One count per discarded packet: only the head (or orphan) beat in IDLE.
  assign drop_event = accept && (state == IDLE) && !head_legal;

  // ---- stage p0: drop statistics ----
  always_ff @(posedge aclk) begin
    if (areset || drop_cnt_clr) begin
      drop_cnt_p0 <= '0;
    end else if (drop_event) begin
      drop_cnt_p0 <= sat_inc(drop_cnt_p0);
    end
  end

  assign drop_cnt = drop_cnt_p0;
`endif

endmodule
